msk_aes_mc_inv: RTL and testbench



---
 rtl/msk_aes_pkg.sv | 20 ++
 rtl/msk_mc_inv_prod.sv | 48 ++++
 rtl/msk_aes_mc_inv.sv | 115 +++++++++++
 tb/tb_msk_aes_mc_inv.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_aes_pkg.sv
// Shared definitions for the masked AES datapath: GF(2^8) reduction constant,
// xtime, and the bit-major share encoding (bit j, share s) -> bus index d*j+s.
package msk_aes_pkg;

    localparam logic [7:0] AES_RED = 8'h1B;

    typedef enum logic {
        MC_INV = 1'b0,
        MC_FWD = 1'b1
    } mc_mode_e;

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? AES_RED : 8'h00);
    endfunction

    function automatic int bit_idx(input int d, input int j, input int s);
        return d * j + s;
    endfunction

endpackage

// File: rtl/msk_mc_inv_prod.sv
// Share-wise GF(2^8) products x09/x0B/x0D/x0E of one d-share byte; with
// MSKAES_MCINV_FWD_EN defined it also provides x02/x03 for forward MixColumns.
module msk_mc_inv_prod
    import msk_aes_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [8*d-1:0] b,
    output logic [8*d-1:0] p09,
    output logic [8*d-1:0] p0b,
    output logic [8*d-1:0] p0d,
    output logic [8*d-1:0] p0e
`ifdef MSKAES_MCINV_FWD_EN
    ,
    output logic [8*d-1:0] p02,
    output logic [8*d-1:0] p03
`endif
);

    // Each share gets its own private xtime chain, so no gate ever sees two share indices.
    for (genvar s = 0; s < d; s++) begin : g_share
        logic [7:0] y;
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;

        for (genvar j = 0; j < 8; j++) begin : g_gather
            assign y[j] = b[bit_idx(d, j, s)];
        end

        assign x2 = xtime(y);
        assign x4 = xtime(x2);
        assign x8 = xtime(x4);

        for (genvar j = 0; j < 8; j++) begin : g_scatter
            localparam int IDX = bit_idx(d, j, s);
            assign p09[IDX] = x8[j] ^ y[j];
            assign p0b[IDX] = x8[j] ^ x2[j] ^ y[j];
            assign p0d[IDX] = x8[j] ^ x4[j] ^ y[j];
            assign p0e[IDX] = x8[j] ^ x4[j] ^ x2[j];
`ifdef MSKAES_MCINV_FWD_EN
            assign p02[IDX] = x2[j];
            assign p03[IDX] = x2[j] ^ y[j];
`endif
        end
    end

endmodule

// File: rtl/msk_aes_mc_inv.sv
// Masked AES InvMixColumns on one column, d Boolean shares, 1-cycle latency.
// Optional macro MSKAES_MCINV_FWD_EN adds port fwd selecting forward MixColumns.
module msk_aes_mc_inv
    import msk_aes_pkg::*;
#(
    parameter int d = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
`ifdef MSKAES_MCINV_FWD_EN
    input  logic           fwd,
`endif
    input  logic [8*d-1:0] b0,
    input  logic [8*d-1:0] b1,
    input  logic [8*d-1:0] b2,
    input  logic [8*d-1:0] b3,
    output logic           out_valid,
    output logic [8*d-1:0] a0,
    output logic [8*d-1:0] a1,
    output logic [8*d-1:0] a2,
    output logic [8*d-1:0] a3
);

    localparam int W = 8 * d;

    logic [W-1:0] b_row [4];
    logic [W-1:0] p09   [4];
    logic [W-1:0] p0b   [4];
    logic [W-1:0] p0d   [4];
    logic [W-1:0] p0e   [4];
    logic [W-1:0] z_inv [4];
    logic [W-1:0] z_sel [4];
    logic [W-1:0] a_q   [4];

    assign b_row[0] = b0;
    assign b_row[1] = b1;
    assign b_row[2] = b2;
    assign b_row[3] = b3;

`ifdef MSKAES_MCINV_FWD_EN
    logic [W-1:0] p02   [4];
    logic [W-1:0] p03   [4];
    logic [W-1:0] z_fwd [4];
`endif

    for (genvar r = 0; r < 4; r++) begin : g_row
        msk_mc_inv_prod #(.d(d)) u_prod (
            .b   (b_row[r]),
            .p09 (p09[r]),
            .p0b (p0b[r]),
            .p0d (p0d[r]),
            .p0e (p0e[r])
`ifdef MSKAES_MCINV_FWD_EN
            ,
            .p02 (p02[r]),
            .p03 (p03[r])
`endif
        );
    end

    // Bus-wide XOR keeps bit positions aligned, so shares are combined only with themselves.
    always_comb begin
        // NOTE: every combinational output is given a value before any branch so no latch can be inferred.
        for (int r = 0; r < 4; r++) begin
            z_inv[r] = '0;
        end
        for (int r = 0; r < 4; r++) begin
            z_inv[r] = p0e[r] ^ p0b[(r + 1) % 4] ^ p0d[(r + 2) % 4] ^ p09[(r + 3) % 4];
        end
    end

`ifdef MSKAES_MCINV_FWD_EN
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            z_fwd[r] = '0;
            z_sel[r] = '0;
        end
        for (int r = 0; r < 4; r++) begin
            z_fwd[r] = p02[r] ^ p03[(r + 1) % 4] ^ b_row[(r + 2) % 4] ^ b_row[(r + 3) % 4];
            z_sel[r] = (mc_mode_e'(fwd) == MC_FWD) ? z_fwd[r] : z_inv[r];
        end
    end
`else
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            z_sel[r] = z_inv[r];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            // NOTE: the data registers are reset too, because a cleared column must read as all zeros.
            for (int r = 0; r < 4; r++) begin
                a_q[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            out_valid <= in_valid;
            if (in_valid) begin
                for (int r = 0; r < 4; r++) begin
                    a_q[r] <= z_sel[r];
                end
            end
        end
    end

    assign a0 = a_q[0];
    assign a1 = a_q[1];
    assign a2 = a_q[2];
    assign a3 = a_q[3];

endmodule

// File: tb/tb_msk_aes_mc_inv.sv
// Self-checking bench for msk_aes_mc_inv: scoreboard on a d=2 instance plus
// fixed-point checks on d=1 and d=3 instances; fwd cases only with MSKAES_MCINV_FWD_EN.
module tb_msk_aes_mc_inv;

    typedef logic [3:0][7:0]  col_t;
    typedef logic [3:0][15:0] bus2_t;
    typedef logic [3:0][23:0] bus3_t;
    typedef struct packed {
        bus2_t bus;
        col_t  plain;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    errors = 0;
    exp_t  sb[$];

    logic  iv2 = 1'b0, ov2;
    bus2_t bi2 = '0, ao2;
    logic  iv1 = 1'b0, ov1;
    col_t  bi1 = '0, ao1;
    logic  iv3 = 1'b0, ov3;
    bus3_t bi3 = '0, ao3;
`ifdef MSKAES_MCINV_FWD_EN
    logic  fwd_s = 1'b0;
`endif

    always #5 clk = ~clk;

    msk_aes_mc_inv #(.d(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2),
`ifdef MSKAES_MCINV_FWD_EN
        .fwd(fwd_s),
`endif
        .b0(bi2[0]), .b1(bi2[1]), .b2(bi2[2]), .b3(bi2[3]),
        .out_valid(ov2), .a0(ao2[0]), .a1(ao2[1]), .a2(ao2[2]), .a3(ao2[3])
    );

    msk_aes_mc_inv #(.d(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1),
`ifdef MSKAES_MCINV_FWD_EN
        .fwd(fwd_s),
`endif
        .b0(bi1[0]), .b1(bi1[1]), .b2(bi1[2]), .b3(bi1[3]),
        .out_valid(ov1), .a0(ao1[0]), .a1(ao1[1]), .a2(ao1[2]), .a3(ao1[3])
    );

    msk_aes_mc_inv #(.d(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(iv3),
`ifdef MSKAES_MCINV_FWD_EN
        .fwd(fwd_s),
`endif
        .b0(bi3[0]), .b1(bi3[1]), .b2(bi3[2]), .b3(bi3[3]),
        .out_valid(ov3), .a0(ao3[0]), .a1(ao3[1]), .a2(ao3[2]), .a3(ao3[3])
    );

    // Reference GF(2^8) multiply: carry-less product then long division by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] t;
        t = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) t ^= 15'(a) << i;
        for (int k = 14; k >= 8; k--)
            if (t[k]) t ^= 15'(9'h11B) << (k - 8);
        return t[7:0];
    endfunction

    function automatic col_t mc(input col_t y, input bit inv);
        logic [7:0] cf [4];
        col_t z;
        if (inv) cf = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int r = 0; r < 4; r++) begin
            z[r] = 8'h00;
            for (int k = 0; k < 4; k++)
                z[r] ^= gmul(cf[(k - r + 4) % 4], y[k]);
        end
        return z;
    endfunction

    function automatic col_t col(input logic [7:0] x0, x1, x2, x3);
        col_t c;
        c[0] = x0; c[1] = x1; c[2] = x2; c[3] = x3;
        return c;
    endfunction

    function automatic bus2_t pack2(input col_t s0, input col_t s1);
        bus2_t b;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 8; j++) begin
                b[r][2*j]   = s0[r][j];
                b[r][2*j+1] = s1[r][j];
            end
        return b;
    endfunction

    function automatic col_t plain2(input bus2_t b);
        col_t c;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 8; j++)
                c[r][j] = b[r][2*j] ^ b[r][2*j+1];
        return c;
    endfunction

    function automatic bus3_t pack3(input col_t s0, input col_t s1, input col_t s2);
        bus3_t b;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 8; j++) begin
                b[r][3*j]   = s0[r][j];
                b[r][3*j+1] = s1[r][j];
                b[r][3*j+2] = s2[r][j];
            end
        return b;
    endfunction

    function automatic col_t plain3(input bus3_t b);
        col_t c;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 8; j++)
                c[r][j] = b[r][3*j] ^ b[r][3*j+1] ^ b[r][3*j+2];
        return c;
    endfunction

    // Scoreboard: every valid d=2 output is compared share-by-share and unmasked.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov2) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: out_valid=1 bus %h with no expected result", ao2);
            end else begin
                e = sb.pop_front();
                if (ao2 !== e.bus || plain2(ao2) !== e.plain) begin
                    errors++;
                    $display("FAIL sb_result: got bus %h plain %h, expected bus %h plain %h",
                             ao2, plain2(ao2), e.bus, e.plain);
                end
            end
        end
    end

    task automatic send2(input col_t s0, input col_t s1, input col_t plain_exp, input bit fw);
        exp_t e;
        @(negedge clk);
        iv2 = 1'b1;
        bi2 = pack2(s0, s1);
`ifdef MSKAES_MCINV_FWD_EN
        fwd_s = fw;
`endif
        e.bus   = pack2(mc(s0, !fw), mc(s1, !fw));
        e.plain = plain_exp;
        sb.push_back(e);
    endtask

    task automatic idle2();
        @(negedge clk);
        iv2 = 1'b0;
        bi2 = bus2_t'({$urandom(), $urandom()});
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (ov2 !== 1'b0 || ao2 !== '0 || ov1 !== 1'b0 || ao1 !== '0 || ov3 !== 1'b0 || ao3 !== '0) begin
            errors++;
            $display("FAIL reset_state: ov %b%b%b a2 %h a1 %h a3 %h, expected all zero",
                     ov1, ov2, ov3, ao2, ao1, ao3);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_kat_mask0();
        bus2_t held;
        send2('0, col(8'h8E, 8'h4D, 8'hA1, 8'hBC), col(8'hDB, 8'h13, 8'h53, 8'h45), 1'b0);
        checks++;
        if (ov2 !== 1'b0) begin
            errors++;
            $display("FAIL kat_latency_pre: out_valid %b before edge, expected 0", ov2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ov2 !== 1'b1 || plain2(ao2) !== col(8'hDB, 8'h13, 8'h53, 8'h45)) begin
            errors++;
            $display("FAIL kat_mask0: out_valid %b plain %h, expected 1 and DB135345 (row0 low)", ov2, plain2(ao2));
        end
        held = pack2('0, col(8'hDB, 8'h13, 8'h53, 8'h45));
        idle2();
        @(posedge clk);
        #1;
        checks++;
        if (ov2 !== 1'b0 || ao2 !== held) begin
            errors++;
            $display("FAIL hold: out_valid %b bus %h, expected 0 and %h", ov2, ao2, held);
        end
    endtask

    task automatic test_kat_masked();
        col_t m;
        m = col_t'($urandom());
        send2(m, col(8'h9F, 8'hDC, 8'h58, 8'h9D) ^ m, col(8'hF2, 8'h0A, 8'h22, 8'h5C), 1'b0);
        idle2();
    endtask

    task automatic test_fixed_points();
        col_t pts [2];
        col_t m0, m1;
        pts[0] = col(8'h01, 8'h01, 8'h01, 8'h01);
        pts[1] = col(8'hC6, 8'hC6, 8'hC6, 8'hC6);
        for (int i = 0; i < 2; i++) begin
            m0 = col_t'($urandom());
            m1 = col_t'($urandom());
            @(negedge clk);
            iv1 = 1'b1;
            bi1 = pts[i];
            iv3 = 1'b1;
            bi3 = pack3(m0, m1, pts[i] ^ m0 ^ m1);
            @(posedge clk);
            #1;
            checks++;
            if (ov1 !== 1'b1 || ao1 !== pts[i]) begin
                errors++;
                $display("FAIL fixed_d1[%0d]: out_valid %b a %h, expected 1 and %h", i, ov1, ao1, pts[i]);
            end
            checks++;
            if (ov3 !== 1'b1 || plain3(ao3) !== pts[i]) begin
                errors++;
                $display("FAIL fixed_d3[%0d]: out_valid %b plain %h, expected 1 and %h", i, ov3, plain3(ao3), pts[i]);
            end
        end
        @(negedge clk);
        iv1 = 1'b0;
        iv3 = 1'b0;
    endtask

    task automatic test_back_to_back();
        col_t m;
        m = col_t'($urandom());
        send2(m, col(8'hD5, 8'hD5, 8'hD7, 8'hD6) ^ m, col(8'hD4, 8'hD4, 8'hD4, 8'hD5), 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (ov2 !== 1'b1 || plain2(ao2) !== col(8'hD4, 8'hD4, 8'hD4, 8'hD5)) begin
            errors++;
            $display("FAIL b2b_first: out_valid %b plain %h, expected 1 and D4D4D4D5 column", ov2, plain2(ao2));
        end
        m = col_t'($urandom());
        send2(m, col(8'h8E, 8'h4D, 8'hA1, 8'hBC) ^ m, col(8'hDB, 8'h13, 8'h53, 8'h45), 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (ov2 !== 1'b1 || plain2(ao2) !== col(8'hDB, 8'h13, 8'h53, 8'h45)) begin
            errors++;
            $display("FAIL b2b_second: out_valid %b plain %h, expected 1 and DB135345 column", ov2, plain2(ao2));
        end
        idle2();
    endtask

    task automatic test_reset_mid();
        send2('0, col(8'hD5, 8'hD5, 8'hD7, 8'hD6), col(8'hD4, 8'hD4, 8'hD4, 8'hD5), 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (ov2 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: out_valid %b, expected 1", ov2);
        end
        #1;
        rst = 1'b1;
        iv2 = 1'b0;
        void'(sb.pop_back());
        #1;
        checks++;
        if (ov2 !== 1'b0 || ao2 !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: out_valid %b bus %h, expected 0 and 0", ov2, ao2);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ov2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: out_valid %b after reset release, expected 0", ov2);
        end
        send2('0, col(8'h8E, 8'h4D, 8'hA1, 8'hBC), col(8'hDB, 8'h13, 8'h53, 8'h45), 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (ov2 !== 1'b1 || plain2(ao2) !== col(8'hDB, 8'h13, 8'h53, 8'h45)) begin
            errors++;
            $display("FAIL rst_mid_first: out_valid %b plain %h, expected 1 and DB135345 column", ov2, plain2(ao2));
        end
        idle2();
    endtask

`ifdef MSKAES_MCINV_FWD_EN
    task automatic test_fwd();
        send2('0, col(8'hDB, 8'h13, 8'h53, 8'h45), col(8'h8E, 8'h4D, 8'hA1, 8'hBC), 1'b1);
        idle2();
    endtask
`endif

    task automatic test_round_trip();
        col_t c, m;
        for (int i = 0; i < 40; i++) begin
            c = col_t'($urandom());
            m = col_t'($urandom());
`ifdef MSKAES_MCINV_FWD_EN
            if (i % 3 == 2) send2(m, c ^ m, mc(c, 1'b0), 1'b1);
            else            send2(m, mc(c, 1'b0) ^ m, c, 1'b0);
`else
            send2(m, mc(c, 1'b0) ^ m, c, 1'b0);
`endif
        end
        idle2();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results never produced, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_kat_mask0();
        test_kat_masked();
        test_fixed_points();
        test_back_to_back();
        test_reset_mid();
`ifdef MSKAES_MCINV_FWD_EN
        test_fwd();
`endif
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
